// File: rtl/proc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : proc_run_ctrl
// Purpose  : Run controller for Top_Processor. It loads a program image into
//            instruction memory over a valid/ready port, sequences the
//            processor reset release, counts run cycles until the processor
//            reports done or a timeout expires, and holds the result for the
//            host until it is acknowledged or a new run is started.
// Ports    : clk, s_reset        - clock, synchronous active-high reset
//            i_ld_*/o_ld_ready   - image load port (valid/ready, last marks end)
//            i_start, i_ack      - run existing image / consume result
//            o_imem_*            - registered instruction memory write port
//            o_proc_reset_n      - processor a_reset_n (low = held in reset)
//            i_proc_done/_cycle  - processor completion status
//            o_busy, o_result_valid, o_timeout, o_run_cycles, o_last_cycle
//                                - run status and held result
// Revision : 1.0 - initial release
// ============================================================================
module proc_run_ctrl #(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 8,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 30,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              s_reset,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [WIDTH-1:0]  i_ld_data,
  input  logic              i_ld_last,
  input  logic              i_start,
  input  logic              i_ack,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [WIDTH-1:0]  o_imem_wdata,
  output logic              o_proc_reset_n,
  input  logic              i_proc_done,
  input  logic [3:0]        i_proc_cycle,
  output logic              o_busy,
  output logic              o_result_valid,
  output logic              o_timeout,
  output logic [CNT_W-1:0]  o_run_cycles,
  output logic [3:0]        o_last_cycle
);

  localparam int c_RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_RESET_PROC = 3'd2,
    S_RUN        = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [c_RST_W-1:0] r_rst_cnt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_imem_we;
  logic [ADDR_W-1:0]  r_imem_addr;
  logic [WIDTH-1:0]   r_imem_wdata;
  logic               r_proc_reset_n;
  logic               r_busy;
  logic               r_result_valid;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_run_cycles;
  logic [3:0]         r_last_cycle;

  logic w_ld_ready;
  logic w_hs;
  logic w_rst_last;
  logic w_cnt_max;
  logic w_enter_reset;

  // Ready is the only combinational output; gating it with s_reset keeps a
  // handshake (and hence a write) from ever coinciding with reset.
  assign w_ld_ready    = !s_reset && ((r_state == S_IDLE) || (r_state == S_LOAD));
  assign w_hs          = i_ld_valid && w_ld_ready;
  assign w_rst_last    = (r_rst_cnt == c_RST_W'(RST_CYCLES - 1));
  assign w_cnt_max     = (r_cnt == CNT_W'(MAX_CYCLES));
  assign w_enter_reset = (w_next == S_RESET_PROC) && (r_state != S_RESET_PROC);

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_next = i_ld_last ? S_RESET_PROC : S_LOAD;
        end else if (i_start) begin
          w_next = S_RESET_PROC;
        end
      end
      S_LOAD: begin
        if ((w_hs && i_ld_last) || i_start) begin
          w_next = S_RESET_PROC;
        end
      end
      S_RESET_PROC: begin
        if (w_rst_last) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (i_proc_done || w_cnt_max) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        // A new run takes priority over a plain acknowledge.
        if (i_start) begin
          w_next = S_RESET_PROC;
        end else if (i_ack) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (s_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath and registered outputs. Status outputs are computed from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (s_reset) begin
      r_rst_cnt      <= '0;
      r_cnt          <= '0;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= '0;
      r_imem_wdata   <= '0;
      r_proc_reset_n <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_timeout      <= 1'b0;
      r_run_cycles   <= '0;
      r_last_cycle   <= '0;
    end else begin
      r_imem_we <= w_hs;
      if (w_hs) begin
        r_imem_addr  <= i_ld_addr;
        r_imem_wdata <= i_ld_data;
      end

      r_proc_reset_n <= (w_next == S_RUN);
      r_busy         <= (w_next == S_RESET_PROC) || (w_next == S_RUN);

      if (w_enter_reset) begin
        r_rst_cnt      <= '0;
        r_cnt          <= '0;
        r_result_valid <= 1'b0;
      end else if (r_state == S_RESET_PROC) begin
        r_rst_cnt <= r_rst_cnt + c_RST_W'(1);
        // Counter already reads 1 in the first RUN cycle.
        if (w_next == S_RUN) begin
          r_cnt <= CNT_W'(1);
        end
      end else if (r_state == S_RUN) begin
        if (w_next == S_RUN) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end else begin
          // Done has priority: timeout is only flagged when done is low.
          r_result_valid <= 1'b1;
          r_timeout      <= !i_proc_done;
          r_run_cycles   <= r_cnt;
          r_last_cycle   <= i_proc_cycle;
        end
      end else if ((r_state == S_DONE) && (w_next != S_DONE)) begin
        r_result_valid <= 1'b0;
      end
    end
  end

  assign o_ld_ready     = w_ld_ready;
  assign o_imem_we      = r_imem_we;
  assign o_imem_addr    = r_imem_addr;
  assign o_imem_wdata   = r_imem_wdata;
  assign o_proc_reset_n = r_proc_reset_n;
  assign o_busy         = r_busy;
  assign o_result_valid = r_result_valid;
  assign o_timeout      = r_timeout;
  assign o_run_cycles   = r_run_cycles;
  assign o_last_cycle   = r_last_cycle;

endmodule
`default_nettype wire

// File: tb/tb_proc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_run_ctrl
// Purpose  : Self-checking bench for proc_run_ctrl. Directed load/run
//            sequences, a table of run-length cases and randomized
//            load-and-run transactions compared against a transaction-level
//            model of the run result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_run_ctrl;

  localparam int WIDTH      = 32;
  localparam int ADDR_W     = 8;
  localparam int RST_CYCLES = 2;
  localparam int MAX_CYCLES = 30;
  localparam int CNT_W      = 16;

  logic              clk = 1'b0;
  logic              s_reset;
  logic              i_ld_valid;
  logic              o_ld_ready;
  logic [ADDR_W-1:0] i_ld_addr;
  logic [WIDTH-1:0]  i_ld_data;
  logic              i_ld_last;
  logic              i_start;
  logic              i_ack;
  logic              o_imem_we;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [WIDTH-1:0]  o_imem_wdata;
  logic              o_proc_reset_n;
  logic              i_proc_done;
  logic [3:0]        i_proc_cycle;
  logic              o_busy;
  logic              o_result_valid;
  logic              o_timeout;
  logic [CNT_W-1:0]  o_run_cycles;
  logic [3:0]        o_last_cycle;

  proc_run_ctrl #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .RST_CYCLES(RST_CYCLES),
    .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .s_reset(s_reset),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready),
    .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data), .i_ld_last(i_ld_last),
    .i_start(i_start), .i_ack(i_ack),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
    .o_proc_reset_n(o_proc_reset_n),
    .i_proc_done(i_proc_done), .i_proc_cycle(i_proc_cycle),
    .o_busy(o_busy), .o_result_valid(o_result_valid), .o_timeout(o_timeout),
    .o_run_cycles(o_run_cycles), .o_last_cycle(o_last_cycle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] img_addr [8];
  logic [WIDTH-1:0]  img_data [8];

  typedef struct {
    int done_at;     // RUN count at which done is raised (0 = never)
    int exp_cycles;
    bit exp_to;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result of a run in which done is raised at RUN count done_at.
  function automatic int model_cycles(input int done_at);
    if (done_at >= 1 && done_at <= MAX_CYCLES) return done_at;
    return MAX_CYCLES;
  endfunction

  function automatic bit model_timeout(input int done_at);
    return !(done_at >= 1 && done_at <= MAX_CYCLES);
  endfunction

  // Loads img_*[0..n-1]; each handshake must produce one write next cycle.
  task automatic load_image(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        i_ld_valid = 1'b0;
        tick();
        chk("gap_no_write", o_imem_we, 0);
      end
      i_ld_valid = 1'b1;
      i_ld_addr  = img_addr[i];
      i_ld_data  = img_data[i];
      i_ld_last  = (i == n - 1);
      chk("ld_ready", o_ld_ready, 1);
      tick();
      chk("imem_we", o_imem_we, 1);
      chk("imem_addr", o_imem_addr, img_addr[i]);
      chk("imem_wdata", o_imem_wdata, img_data[i]);
    end
    i_ld_valid = 1'b0;
    i_ld_last  = 1'b0;
  endtask

  // Entered in the first RESET_PROC cycle; returns in the DONE cycle.
  task automatic run_check(input int done_at);
    int rc;
    int k;
    bit ended;
    logic [3:0] pc;
    logic [3:0] last_pc;
    chk("entry_busy", o_busy, 1);
    chk("entry_valid", o_result_valid, 0);
    chk("entry_ld_ready", o_ld_ready, 0);
    rc = 0;
    while (!o_proc_reset_n && rc < 20) begin
      rc++;
      tick();
    end
    chk("rst_len", rc, RST_CYCLES);
    chk("we_single_pulse", o_imem_we, 0);
    k = 1;
    ended = 1'b0;
    last_pc = '0;
    while (!ended && k <= 100) begin
      chk("run_reset_n", o_proc_reset_n, 1);
      pc = 4'($urandom);
      i_proc_cycle = pc;
      i_proc_done  = (k == done_at);
      last_pc = pc;
      tick();
      i_proc_done = 1'b0;
      if (o_result_valid) ended = 1'b1;
      else k++;
    end
    chk("run_ended", ended, 1);
    chk("run_len", k, model_cycles(done_at));
    chk("run_cycles", o_run_cycles, model_cycles(done_at));
    chk("timeout", o_timeout, model_timeout(done_at));
    chk("last_cycle", o_last_cycle, last_pc);
    chk("done_reset_n", o_proc_reset_n, 0);
    chk("done_busy", o_busy, 0);
  endtask

  task automatic do_ack();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    chk("ack_valid", o_result_valid, 0);
    chk("ack_busy", o_busy, 0);
    chk("ack_ld_ready", o_ld_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int done_at;
    int rc;

    vecs[0] = '{done_at: 0,  exp_cycles: 30, exp_to: 1'b1};
    vecs[1] = '{done_at: 1,  exp_cycles: 1,  exp_to: 1'b0};
    vecs[2] = '{done_at: 29, exp_cycles: 29, exp_to: 1'b0};
    vecs[3] = '{done_at: 31, exp_cycles: 30, exp_to: 1'b1};
    vecs[4] = '{done_at: 12, exp_cycles: 12, exp_to: 1'b0};

    s_reset = 1'b1; i_ld_valid = 1'b0; i_ld_addr = '0; i_ld_data = '0;
    i_ld_last = 1'b0; i_start = 1'b0; i_ack = 1'b0;
    i_proc_done = 1'b0; i_proc_cycle = '0;

    // Reset values
    tick();
    chk("rst_ld_ready_forced", o_ld_ready, 0);
    tick();
    s_reset = 1'b0;
    #1;
    chk("rst_we", o_imem_we, 0);
    chk("rst_addr", o_imem_addr, 0);
    chk("rst_wdata", o_imem_wdata, 0);
    chk("rst_reset_n", o_proc_reset_n, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_result_valid, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_run_cycles", o_run_cycles, 0);
    chk("rst_last_cycle", o_last_cycle, 0);
    chk("rst_ld_ready", o_ld_ready, 1);

    // Directed 4-word image, done at count 7
    img_addr[0] = 8'd0; img_data[0] = 32'h0050_0093;
    img_addr[1] = 8'd1; img_data[1] = 32'h00A0_0113;
    img_addr[2] = 8'd2; img_data[2] = 32'h0020_81B3;
    img_addr[3] = 8'd3; img_data[3] = 32'h0000_0013;
    load_image(4, 1'b0);
    run_check(7);
    do_ack();

    // Table of run-length cases, each started with i_start
    for (int v = 0; v < 5; v++) begin
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      run_check(vecs[v].done_at);
      chk("tbl_cycles", o_run_cycles, vecs[v].exp_cycles);
      chk("tbl_timeout", o_timeout, vecs[v].exp_to);
      do_ack();
    end

    // Done exactly at the timeout count, then start+ack together
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    run_check(MAX_CYCLES);
    i_start = 1'b1;
    i_ack   = 1'b1;
    tick();
    i_start = 1'b0;
    i_ack   = 1'b0;
    chk("start_ack_busy", o_busy, 1);
    chk("start_ack_valid", o_result_valid, 0);
    run_check(3);
    do_ack();

    // Reset at RUN count 5; load offered during RUN is refused
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    rc = 0;
    while (!o_proc_reset_n && rc < 20) begin
      rc++;
      tick();
    end
    for (int k = 1; k < 5; k++) begin
      i_ld_valid = (k == 2);
      i_ld_addr  = 8'h55;
      i_ld_data  = 32'hDEAD_BEEF;
      if (k == 2) chk("run_ld_ready", o_ld_ready, 0);
      tick();
      if (k == 2) chk("run_no_write", o_imem_we, 0);
    end
    i_ld_valid = 1'b0;
    chk("run5_reset_n", o_proc_reset_n, 1);
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
    #1;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_valid", o_result_valid, 0);
    chk("midrst_reset_n", o_proc_reset_n, 0);
    chk("midrst_run_cycles", o_run_cycles, 0);
    chk("midrst_we", o_imem_we, 0);
    chk("midrst_ld_ready", o_ld_ready, 1);

    // Randomized images and run lengths
    for (int it = 0; it < 15; it++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        img_addr[i] = 8'($urandom);
        img_data[i] = $urandom;
      end
      load_image(n, 1'b1);
      done_at = $urandom_range(1, 40);
      run_check(done_at);
      do_ack();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
